// File: rtl/act_fixed_pkg.sv
// Shared Q8.24 fixed-point definitions and activation table knots for the
// forward activation unit and its inverse solver.
package act_fixed_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 24;
    localparam int ADDR_W = DATA_W - FRAC_W;

    typedef logic signed [DATA_W-1:0] q8_24_t;

    localparam q8_24_t Z_MIN = 32'sh8000_0000;
    localparam q8_24_t Z_MAX = 32'sh7FFF_FFFF;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CHK_LO = 3'd1;
    localparam state_t ST_CHK_HI = 3'd2;
    localparam state_t ST_SEARCH = 3'd3;
    localparam state_t ST_LOAD   = 3'd4;
    localparam state_t ST_DIV    = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

    // Knots are counted in units of 2^-2 (2^22 LSBs). Outer segments rise by
    // one unit; segments -64..63 rise by 4,5,6,7 units in turn (slope >= 1).
    localparam int KNOT_UNIT   = 4194304;
    localparam int KNOT_ORIGIN = -416;
    // One segment whose next() equals its base(): a step in the curve.
    localparam int FLAT_SEG    = -100;

    function automatic q8_24_t act_knot(input int k);
        int n;
        int r;
        int units;
        n = k + 64;
        r = n & 3;
        if (k <= -64) begin
            units = KNOT_ORIGIN + (k + 128);
        end else if (k <= 64) begin
            units = KNOT_ORIGIN + 64 + 22 * (n >>> 2) + 4 * r + (r * (r - 1)) / 2;
        end else begin
            units = KNOT_ORIGIN + 64 + 704 + (k - 64);
        end
        return q8_24_t'(units * KNOT_UNIT);
    endfunction

endpackage

// File: rtl/act_inv_table.sv
// Combinational activation ROM: segment address -> {base, next} knot values.
// Contents match the forward activation unit's table.
module act_inv_table
    import act_fixed_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output q8_24_t            seg_base,
    output q8_24_t            seg_next
);

    q8_24_t base_rom [1<<ADDR_W];
    q8_24_t next_rom [1<<ADDR_W];

    genvar gi;
    generate
        for (gi = 0; gi < (1 << ADDR_W); gi++) begin : g_rom
            // Address is the two's-complement segment index s[7:0].
            localparam int     SEG    = (gi < 128) ? gi : gi - 256;
            localparam q8_24_t BASE_V = act_knot(SEG);
            localparam q8_24_t NEXT_V = (SEG == FLAT_SEG) ? act_knot(SEG) : act_knot(SEG + 1);
            assign base_rom[gi] = BASE_V;
            assign next_rom[gi] = NEXT_V;
        end
    endgenerate

    assign seg_base = base_rom[addr];
    assign seg_next = next_rom[addr];

endmodule

// File: rtl/activation_inverse_solver.sv
// Inverse of the LUT+interpolation activation: binary-search the segment, then
// restoring-divide the fraction. Define ACT_INV_ROUND_EN for round-half-up frac.
module activation_inverse_solver
    import act_fixed_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] z_out,
    output logic              sat
);

`ifdef ACT_INV_ROUND_EN
    localparam int DIV_ITERS = FRAC_W + 1;
`else
    localparam int DIV_ITERS = FRAC_W;
`endif

    state_t                 state_q, state_d;
    q8_24_t                 a_q, a_d;
    logic [ADDR_W-1:0]      u_q, u_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [DATA_W-1:0]      rem_q, rem_d;
    logic [DATA_W-1:0]      den_q, den_d;
    logic [DIV_ITERS-2:0]   quo_q, quo_d;
    logic [DATA_W-1:0]      z_q, z_d;
    logic                   sat_q, sat_d;

    logic [ADDR_W-1:0]      u_trial;
    logic [ADDR_W-1:0]      s_addr;
    logic [ADDR_W-1:0]      tbl_addr;
    q8_24_t                 seg_base;
    q8_24_t                 seg_next;
    logic [DATA_W-1:0]      diff_num;
    logic [DATA_W-1:0]      diff_den;
    logic [DATA_W:0]        rem_shift;
    logic [DATA_W-1:0]      rem_sub;
    logic                   q_bit;
    logic [DIV_ITERS-1:0]   quo_next;
    logic [FRAC_W-1:0]      frac_final;

    act_inv_table u_table (
        .addr     (tbl_addr),
        .seg_base (seg_base),
        .seg_next (seg_next)
    );

    // u holds s+128, so flipping the MSB gives the table address s[7:0].
    assign u_trial = u_q | (8'h80 >> cnt_q[2:0]);
    assign s_addr  = u_q ^ 8'h80;

    always_comb begin
        tbl_addr = s_addr;
        case (state_q)
            ST_CHK_LO: tbl_addr = 8'h80;
            ST_CHK_HI: tbl_addr = 8'h7F;
            ST_SEARCH: tbl_addr = u_trial ^ 8'h80;
            default:   tbl_addr = s_addr;
        endcase
    end

    // Both differences are non-negative once the segment is found.
    assign diff_num  = a_q - seg_base;
    assign diff_den  = seg_next - seg_base;
    assign rem_shift = {rem_q, 1'b0};
    assign q_bit     = (rem_shift >= {1'b0, den_q});
    assign rem_sub   = rem_shift[DATA_W-1:0] - den_q;
    assign quo_next  = {quo_q, q_bit};

`ifdef ACT_INV_ROUND_EN
    logic [FRAC_W:0] frac_sum;
    always_comb begin
        frac_sum   = {1'b0, quo_next[DIV_ITERS-1:1]} + {{FRAC_W{1'b0}}, quo_next[0]};
        frac_final = frac_sum[FRAC_W] ? {FRAC_W{1'b1}} : frac_sum[FRAC_W-1:0];
    end
`else
    assign frac_final = quo_next;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        u_d     = u_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        den_d   = den_q;
        quo_d   = quo_q;
        z_d     = z_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    sat_d   = 1'b0;
                    state_d = ST_CHK_LO;
                end
            end
            ST_CHK_LO: begin
                if (a_q < seg_base) begin
                    z_d   = Z_MIN;
                    sat_d = 1'b1;
                end
                state_d = ST_CHK_HI;
            end
            ST_CHK_HI: begin
                if (sat_q) begin
                    state_d = ST_DONE;
                end else if (a_q >= seg_next) begin
                    z_d     = Z_MAX;
                    sat_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    u_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (seg_base <= a_q) begin
                    u_d = u_trial;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd7) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rem_d = diff_num;
                den_d = diff_den;
                quo_d = '0;
                cnt_d = '0;
                if (diff_den == '0) begin
                    z_d     = {s_addr, {FRAC_W{1'b0}}};
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                rem_d = q_bit ? rem_sub : rem_shift[DATA_W-1:0];
                quo_d = quo_next[DIV_ITERS-2:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITERS - 1)) begin
                    z_d     = {s_addr, frac_final};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            u_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            quo_q   <= '0;
            z_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            u_q     <= u_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            den_q   <= den_d;
            quo_q   <= quo_d;
            z_q     <= z_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign z_out     = z_q;
    assign sat       = sat_q;

endmodule
